instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives the word address to the combinational instruction memory.
- Captures the returned instruction word with its PC into a small FIFO.
- Hands {pc, instruction} pairs to decode over a valid/ready handshake; supports stall (halt), branch redirect with flush, and a fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- address  output  32  byte address to instruction memory; equals pc
- instruction  input  32  word returned combinationally by memory for the current address
- halt  input  1  suspends fetching while high; FIFO still drains
- redirectValid  input  1  branch/jump redirect request
- redirectTarget  input  32  new PC
- outValid  output  1  FIFO head valid
- outReady  input  1  decode accepts head
- outInstr  output  32  head instruction
- outPc  output  32  PC of head instruction
- fetchCount  output  32  count of words pushed since reset, wraps mod 2^32
- fault  output  1  alignment fault (see Optional Feature); constant 0 otherwise

Behaviour:
- Interface: one clock domain (clk); reset asynchronous active-high. All state is reset immediately on reset assertion, independent of clk.
- Reset values:
  - pc = RESET_PC, so address = RESET_PC
  - FIFO empty, so outValid=0; outInstr=0 and outPc=0 while empty
  - fetchCount=0, fault=0, state=FETCH
- Memory timing: instruction is valid in the same cycle address is presented; no request/ack signalling.
- States:
  - FETCH: normal operation.
  - FAULT: only when IFU_ALIGN_CHECK_EN is defined; exited only by reset.
- Per-edge priority in FETCH:
  1. redirectValid=1:
     - FIFO flushed (count=0); pop ignored.
     - pc <= {redirectTarget[31:2], 2'b00}; no push this cycle.
     - outValid=0 in the following cycle.
  2. Otherwise, push when halt=0 AND (count<DEPTH OR pop this cycle):
     - enqueue {pc, instruction}
     - pc <= pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0)
     - fetchCount+1
  3. Pop when outValid && outReady. Simultaneous push and pop leaves count unchanged, including when full.
- Latency: the first instruction appears on outValid exactly 1 cycle after reset deasserts (one edge). Steady-state throughput is 1 word/cycle when outReady stays high.
- Full FIFO with no pop:
  - pc holds; address is stable.
  - Fetching resumes on the edge where a pop occurs.
- halt rising mid-stream: the in-flight address is not consumed; pc holds.
- halt=1 and redirectValid=1 together: redirect still applies and the FIFO is flushed.
- FIFO output ordering is strictly in PC order between redirects.
- outInstr and outPc are registered (FIFO storage), never combinational from instruction.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - redirectValid with redirectTarget[1:0]≠0 moves the block to FAULT and sets fault=1 on that edge.
  - The FIFO is flushed and pc <= redirectTarget unmodified (for debug).
  - No further pushes; outValid=0; redirects are ignored.
  - Only reset clears FAULT.
- Undefined:
  - Target low bits are silently masked to 2'b00.
  - fault is tied to 0 and FAULT state logic is absent.

Decomposition:
- Shared package ifu_pkg:
  - WORD_W=32, INSTR_BYTES=4
  - state enum {FETCH, FAULT}
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
- Natural sub-module fetch_fifo:
  - parameterised DEPTH
  - flush/push/pop ports
  - count/full/empty outputs
  - instantiated once, holding fetch_entry_t

Test Plan:
- Reset release, memory words 0..3 = A,B,C,D, outReady=1 -> outValid high 1 cycle later; outPc/outInstr sequence 0/A, 4/B, 8/C, 12/D on consecutive cycles; fetchCount=4.
- outReady=0 for 5 cycles from reset -> exactly DEPTH=2 entries (pc 0,4); address holds at 8; outReady=1 -> 0,4,8 delivered in order, no duplicates or gaps.
- Redirect to 32'h40 while FIFO holds pc 8,12 -> next cycle outValid=0; then outPc=0x40, 0x44; entries 8,12 never appear.
- halt=1 for 3 cycles mid-stream -> address and fetchCount frozen; FIFO drains; on release fetch resumes at held pc.
- pc wrap: RESET_PC=32'hFFFF_FFF8 -> outPc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFU_ALIGN_CHECK_EN, redirect to 32'h42 -> fault=1 next cycle, outValid=0 permanently; async reset pulse -> fault=0, address=RESET_PC. Without the macro, same stimulus -> fetch resumes at 0x40.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by fetch_fifo and instr_fetch_unit.
package ifu_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instruction} entries for decode.
// Flush has priority over push/pop; a simultaneous push and pop is allowed when full.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  fetch_entry_t       pushEntry_i,
    output fetch_entry_t       headEntry_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign headEntry_o = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o && !flush_i;
    assign doPush = push_i && (!full_o || doPop) && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (doPush) begin
            mem_q[wrPtr_q] <= pushEntry_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads combinational memory and queues {pc, instr} for decode.
// Optional macro IFU_ALIGN_CHECK_EN enables a sticky FAULT state on misaligned redirect targets.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] instruction,
    input  logic              halt,
    input  logic              redirectValid,
    input  logic [WORD_W-1:0] redirectTarget,
    output logic              outValid,
    input  logic              outReady,
    output logic [WORD_W-1:0] outInstr,
    output logic [WORD_W-1:0] outPc,
    output logic [WORD_W-1:0] fetchCount,
    output logic              fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] fetchCount_q, fetchCount_d;
    logic              flush;
    logic              push;
    logic              popReq;
    fetch_entry_t      pushEntry;
    fetch_entry_t      headEntry;
    logic [CNT_W-1:0]  fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;

    assign address    = pc_q;
    assign fetchCount = fetchCount_q;
    assign outValid   = (fifoCount != '0);
    assign popReq     = outValid && outReady;
    assign pushEntry  = '{pc: pc_q, instr: instruction};
    assign outInstr   = fifoEmpty ? '0 : headEntry.instr;
    assign outPc      = fifoEmpty ? '0 : headEntry.pc;

`ifdef IFU_ALIGN_CHECK_EN
    ifu_state_e state_q, state_d;

    assign fault = (state_q == FAULT);

    // A misaligned redirect parks the unit in FAULT with the raw target kept in pc for debug.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetchCount_d = fetchCount_q;
        flush        = 1'b0;
        push         = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirectValid) begin
                    flush = 1'b1;
                    pc_d  = redirectTarget;
                    if (redirectTarget[1:0] != 2'b00) state_d = FAULT;
                end else if (!halt && (!fifoFull || popReq)) begin
                    push         = 1'b1;
                    pc_d         = pc_q + WORD_W'(INSTR_BYTES);
                    fetchCount_d = fetchCount_q + 1'b1;
                end
            end
            FAULT: flush = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end
`else
    assign fault = 1'b0;

    // Redirect beats push; target low bits are masked to keep the pc word aligned.
    always_comb begin
        pc_d         = pc_q;
        fetchCount_d = fetchCount_q;
        flush        = 1'b0;
        push         = 1'b0;
        if (redirectValid) begin
            flush = 1'b1;
            pc_d  = redirectTarget & ~WORD_W'(INSTR_BYTES - 1);
        end else if (!halt && (!fifoFull || popReq)) begin
            push         = 1'b1;
            pc_d         = pc_q + WORD_W'(INSTR_BYTES);
            fetchCount_d = fetchCount_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            fetchCount_q <= '0;
        end else begin
            pc_q         <= pc_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .push_i      (push),
        .pop_i       (popReq),
        .pushEntry_i (pushEntry),
        .headEntry_o (headEntry),
        .count_o     (fifoCount),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit, plus a second instance for pc wraparound.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, instruction;
    logic        halt, redirectValid, outReady;
    logic [31:0] redirectTarget;
    logic        outValid, fault;
    logic [31:0] outInstr, outPc, fetchCount;

    logic [31:0] address2, instruction2;
    logic        outValid2, fault2;
    logic [31:0] outInstr2, outPc2, fetchCount2;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    // Memory image: each word is a distinct function of its byte address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign instruction  = memWord(address);
    assign instruction2 = memWord(address2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .address(address), .instruction(instruction),
        .halt(halt), .redirectValid(redirectValid), .redirectTarget(redirectTarget),
        .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outPc(outPc),
        .fetchCount(fetchCount), .fault(fault)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dutWrap (
        .clk(clk), .reset(reset), .address(address2), .instruction(instruction2),
        .halt(1'b0), .redirectValid(1'b0), .redirectTarget(32'h0),
        .outValid(outValid2), .outReady(1'b1), .outInstr(outInstr2), .outPc(outPc2),
        .fetchCount(fetchCount2), .fault(fault2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic rv, input logic [31:0] rt, input logic rdy);
        halt           = h;
        redirectValid  = rv;
        redirectTarget = rt;
        outReady       = rdy;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #12;
        checkOutput("rst_address", address, 32'h0);
        checkOutput("rst_outValid", {31'b0, outValid}, 32'h0);
        checkOutput("rst_outPc", outPc, 32'h0);
        checkOutput("rst_outInstr", outInstr, 32'h0);
        checkOutput("rst_fetchCount", fetchCount, 32'h0);
        checkOutput("rst_fault", {31'b0, fault}, 32'h0);
        checkOutput("rst_wrapAddress", address2, 32'hFFFF_FFF8);
        reset = 1'b0;

        // Streaming with outReady high: one word per cycle in pc order.
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stream_outValid", {31'b0, outValid}, 32'h1);
            checkOutput("stream_outPc", outPc, 32'(4 * i));
            checkOutput("stream_outInstr", outInstr, memWord(32'(4 * i)));
            if (i < 3) checkOutput("wrap_outPc", outPc2, 32'hFFFF_FFF8 + 32'(4 * i));
        end
        checkOutput("stream_fetchCount", fetchCount, 32'd4);

        // Asynchronous reset mid-cycle, then back-pressure until the FIFO fills.
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_address", address, 32'h0);
        checkOutput("async_fetchCount", fetchCount, 32'h0);
        checkOutput("async_outValid", {31'b0, outValid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("full_address", address, 32'h8);
        checkOutput("full_fetchCount", fetchCount, 32'd2);
        checkOutput("full_outPc", outPc, 32'h0);
        outReady = 1'b1;
        tick();
        checkOutput("drain_outPc1", outPc, 32'h4);
        checkOutput("drain_address1", address, 32'hC);
        tick();
        checkOutput("drain_outPc2", outPc, 32'h8);
        checkOutput("drain_instr2", outInstr, memWord(32'h8));
        checkOutput("drain_fetchCount", fetchCount, 32'd4);

        // Redirect while the FIFO holds pc 8 and 12.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
        tick();
        checkOutput("redir_outValid", {31'b0, outValid}, 32'h0);
        checkOutput("redir_address", address, 32'h40);
        checkOutput("redir_outPc", outPc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("redir_outPc1", outPc, 32'h40);
        checkOutput("redir_instr1", outInstr, memWord(32'h40));
        tick();
        checkOutput("redir_outPc2", outPc, 32'h44);
        checkOutput("redir_fetchCount", fetchCount, 32'd6);

        // Halt for three cycles: pc and count freeze while the FIFO drains.
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("halt_outValid", {31'b0, outValid}, 32'h0);
            checkOutput("halt_address", address, 32'h48);
            checkOutput("halt_fetchCount", fetchCount, 32'd6);
        end
        halt = 1'b0;
        tick();
        checkOutput("resume_outPc", outPc, 32'h48);
        checkOutput("resume_fetchCount", fetchCount, 32'd7);
        checkOutput("resume_address", address, 32'h4C);

        // Misaligned redirect target.
        applyStimulus(1'b0, 1'b1, 32'h42, 1'b1);
        tick();
        checkOutput("misal_outValid", {31'b0, outValid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IFU_ALIGN_CHECK_EN
        checkOutput("misal_fault", {31'b0, fault}, 32'h1);
        checkOutput("misal_address", address, 32'h42);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("fault_outValid", {31'b0, outValid}, 32'h0);
            checkOutput("fault_sticky", {31'b0, fault}, 32'h1);
        end
        applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
        tick();
        checkOutput("fault_redirIgnored", address, 32'h42);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
`else
        checkOutput("misal_fault", {31'b0, fault}, 32'h0);
        checkOutput("misal_address", address, 32'h40);
        tick();
        checkOutput("misal_outPc", outPc, 32'h40);
        checkOutput("misal_outValid2", {31'b0, outValid}, 32'h1);
`endif
        #3;
        reset = 1'b1;
        #1;
        checkOutput("final_rst_fault", {31'b0, fault}, 32'h0);
        checkOutput("final_rst_address", address, 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("final_outPc", outPc, 32'h0);
        checkOutput("final_outValid", {31'b0, outValid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
